riscv_processor: RTL and testbench

Single-cycle RV32I integer core with on-chip instruction ROM and byte-addressed data RAM; the top-level CPU block of the design. Executes one instruction per rising clock edge from PC 0 after reset. Internal register file and data memory are reachable by hierarchical path for preload and dump by the system bench.

---
 rtl/riscv_pkg.sv | 66 ++++++
 rtl/riscv_alu.sv | 33 +++
 rtl/riscv_processor.sv | 230 +++++++++++++++++++++++
 tb/tb_riscv_processor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: size defaults, opcode/funct constants, ALU and writeback selects.
// Latency: n/a (types and constants only). Backpressure: n/a.
package riscv_pkg;

  localparam int INSTR_MEM_SIZE_DEF = 1024;
  localparam int DATA_MEM_SIZE_DEF  = 256;
  localparam int GPR_SIZE_DEF       = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B, ALU_MUL
  } alu_op_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_t;

  // Base (funct7 = 0) operation for an OP / OP-IMM funct3.
  function automatic alu_op_t f3_alu_op(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu.sv
// 32-bit RV32I ALU; MUL (low 32 bits) only when RISCV_MUL_EN is defined.
// Latency: combinational. Backpressure: none.
module riscv_alu
  import riscv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << b[4:0];
      ALU_SLT:    y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {31'd0, a < b};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> b[4:0];
      ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
`ifdef RISCV_MUL_EN
      ALU_MUL:    y = a * b;
`endif
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/riscv_processor.sv
// Single-cycle RV32I core with instruction ROM ("IM.dat") and byte data RAM; RISCV_MUL_EN adds MUL.
// Latency: one instruction per rising edge, state commits on the edge. Backpressure: none.
module riscv_processor
  import riscv_pkg::*;
#(
  parameter int INSTR_MEM_SIZE = INSTR_MEM_SIZE_DEF,
  parameter int DATA_MEM_SIZE  = DATA_MEM_SIZE_DEF,
  parameter int GPR_SIZE       = GPR_SIZE_DEF
) (
  input logic clk,
  input logic rst_n
);

  localparam int IA_W = $clog2(INSTR_MEM_SIZE);
  localparam int DA_W = $clog2(DATA_MEM_SIZE);
  localparam int GA_W = $clog2(GPR_SIZE);

  logic [31:0] pc, pc_nxt, pc_seq;
  logic [31:0] instr;
  logic [31:0] rs1_val, rs2_val, wb_dat;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [31:0] ld_raw, ld_val, jalr_tgt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, st_len;
  logic        rf_we, mem_we, br_take, eq, lt, ltu;
  alu_op_t     alu_op;
  wb_sel_t     wb_sel;

  if (1) begin : Instruction_Memory
    logic [7:0] InstrMem [0:INSTR_MEM_SIZE-1];

    initial begin
      for (int i = 0; i < INSTR_MEM_SIZE; i++) InstrMem[i] = 8'h00;
    end

    always_comb begin
      instr = '0;
      for (int k = 0; k < 4; k++)
        instr[8*k +: 8] = InstrMem[IA_W'((pc + 32'(k)) % 32'(INSTR_MEM_SIZE))];
    end
  end

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  if (1) begin : Register_File
    logic [31:0] GPR [0:GPR_SIZE-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < GPR_SIZE; i++) GPR[i] <= '0;
      end else if (rf_we && rd != 5'd0) begin
        GPR[GA_W'(rd)] <= wb_dat;
      end
    end

    assign rs1_val = (rs1 == 5'd0) ? '0 : GPR[GA_W'(rs1)];
    assign rs2_val = (rs2 == 5'd0) ? '0 : GPR[GA_W'(rs2)];
  end

  assign eq       = rs1_val == rs2_val;
  assign lt       = $signed(rs1_val) < $signed(rs2_val);
  assign ltu      = rs1_val < rs2_val;
  assign pc_seq   = pc + 32'd4;
  assign jalr_tgt = (rs1_val + imm_i) & ~32'd1;

  // Anything not decoded below leaves every enable low and falls through to PC+4.
  always_comb begin
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    br_take = 1'b0;
    st_len  = 3'd0;
    alu_op  = ALU_ADD;
    alu_a   = rs1_val;
    alu_b   = rs2_val;
    wb_sel  = WB_ALU;
    pc_nxt  = pc_seq;
    case (opcode)
      OPC_LUI: begin
        rf_we  = 1'b1;
        alu_op = ALU_PASS_B;
        alu_b  = imm_u;
      end
      OPC_AUIPC: begin
        rf_we = 1'b1;
        alu_a = pc;
        alu_b = imm_u;
      end
      OPC_JAL: begin
        rf_we  = 1'b1;
        wb_sel = WB_LINK;
        pc_nxt = pc + imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          rf_we  = 1'b1;
          wb_sel = WB_LINK;
          pc_nxt = jalr_tgt;
        end
      end
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ:  br_take = eq;
          F3_BNE:  br_take = !eq;
          F3_BLT:  br_take = lt;
          F3_BGE:  br_take = !lt;
          F3_BLTU: br_take = ltu;
          F3_BGEU: br_take = !ltu;
          default: br_take = 1'b0;
        endcase
        if (br_take) pc_nxt = pc + imm_b;
      end
      OPC_LOAD: begin
        alu_b = imm_i;
        if (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) begin
          rf_we  = 1'b1;
          wb_sel = WB_MEM;
        end
      end
      OPC_STORE: begin
        alu_b = imm_s;
        case (funct3)
          F3_B:    st_len = 3'd1;
          F3_H:    st_len = 3'd2;
          F3_W:    st_len = 3'd4;
          default: st_len = 3'd0;
        endcase
        mem_we = st_len != 3'd0;
      end
      OPC_OP_IMM: begin
        alu_b = imm_i;
        case (funct3)
          F3_SLL: begin
            rf_we  = funct7 == F7_BASE;
            alu_op = ALU_SLL;
          end
          F3_SR: begin
            rf_we  = funct7 == F7_BASE || funct7 == F7_ALT;
            alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          end
          default: begin
            rf_we  = 1'b1;
            alu_op = f3_alu_op(funct3);
          end
        endcase
      end
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          rf_we  = 1'b1;
          alu_op = f3_alu_op(funct3);
        end else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)) begin
          rf_we  = 1'b1;
          alu_op = (funct3 == F3_ADD) ? ALU_SUB : ALU_SRA;
        end
`ifdef RISCV_MUL_EN
        else if (funct7 == F7_MULDIV && funct3 == F3_ADD) begin
          rf_we  = 1'b1;
          alu_op = ALU_MUL;
        end
`endif
      end
      default: ;
    endcase
  end

  riscv_alu u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  if (1) begin : Data_Memory
    logic [7:0] DataMem [0:DATA_MEM_SIZE-1];

    // Each byte wraps independently, so misaligned words straddling the top of RAM still work.
    always_comb begin
      ld_raw = '0;
      for (int k = 0; k < 4; k++)
        ld_raw[8*k +: 8] = DataMem[DA_W'((alu_y + 32'(k)) % 32'(DATA_MEM_SIZE))];
    end

    // rst_n gate keeps a store from landing on an edge that sees reset held.
    always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
        for (int k = 0; k < 4; k++)
          if (3'(k) < st_len)
            DataMem[DA_W'((alu_y + 32'(k)) % 32'(DATA_MEM_SIZE))] <= rs2_val[8*k +: 8];
      end
    end
  end

  always_comb begin
    ld_val = ld_raw;
    case (funct3)
      F3_B:    ld_val = {{24{ld_raw[7]}}, ld_raw[7:0]};
      F3_H:    ld_val = {{16{ld_raw[15]}}, ld_raw[15:0]};
      F3_BU:   ld_val = {24'd0, ld_raw[7:0]};
      F3_HU:   ld_val = {16'd0, ld_raw[15:0]};
      default: ld_val = ld_raw;
    endcase
  end

  always_comb begin
    wb_dat = alu_y;
    case (wb_sel)
      WB_MEM:  wb_dat = ld_val;
      WB_LINK: wb_dat = pc_seq;
      default: wb_dat = alu_y;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else        pc <= pc_nxt % 32'(INSTR_MEM_SIZE);
  end

endmodule

// File: tb/tb_riscv_processor.sv
// System bench for riscv_processor: preloads ROM/RAM by hierarchy, runs to a self-loop, scores architectural state.
// Expected state is queued when the program is loaded and popped once the core reaches the halt PC.
module tb_riscv_processor;
  import riscv_pkg::*;

  localparam logic [31:0] HALT_PC = 32'd112;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_processor RISC_V_CPU_inst (
    .clk   (clk),
    .rst_n (rst_n)
  );

  typedef struct packed {
    logic        is_mem;
    logic [7:0]  idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], OPC_STORE};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], OPC_BRANCH};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, int op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], OPC_JAL};
  endfunction

  task automatic put_word(input int widx, input logic [31:0] w);
    for (int k = 0; k < 4; k++)
      RISC_V_CPU_inst.Instruction_Memory.InstrMem[widx*4 + k] = w[8*k +: 8];
  endtask

  task automatic load_program();
    for (int i = 0; i < INSTR_MEM_SIZE_DEF; i++)
      RISC_V_CPU_inst.Instruction_Memory.InstrMem[i] = 8'h00;
    put_word(0,  enc_i(5, 0, 0, 1, OPC_OP_IMM));            // addi x1,x0,5
    put_word(1,  enc_i(-3, 0, 0, 2, OPC_OP_IMM));           // addi x2,x0,-3
    put_word(2,  enc_r(0, 2, 1, 0, 3, OPC_OP));             // add  x3,x1,x2
    put_word(3,  enc_r(32, 2, 1, 0, 4, OPC_OP));            // sub  x4,x1,x2
    put_word(4,  enc_i(0, 0, 2, 5, OPC_LOAD));              // lw   x5,0(x0)
    put_word(5,  enc_i(3, 0, 0, 6, OPC_LOAD));              // lb   x6,3(x0)
    put_word(6,  enc_i(0, 0, 4, 7, OPC_LOAD));              // lbu  x7,0(x0)
    put_word(7,  enc_s(8, 5, 0, 2));                        // sw   x5,8(x0)
    put_word(8,  enc_s(12, 1, 0, 0));                       // sb   x1,12(x0)
    put_word(9,  enc_r(1, 2, 1, 0, 8, OPC_OP));             // mul  x8,x1,x2
    put_word(10, enc_i(7, 0, 0, 0, OPC_OP_IMM));            // addi x0,x0,7
    put_word(11, 32'h0000_0000);
    put_word(12, enc_i(-1, 1, 0, 1, OPC_OP_IMM));           // loop: addi x1,x1,-1
    put_word(13, enc_b(-4, 0, 1, 1));                       // bne  x1,x0,loop
    put_word(14, enc_j(8, 9));                              // jal  x9,+8
    put_word(15, enc_i(99, 0, 0, 10, OPC_OP_IMM));          // skipped
    put_word(16, enc_i(1, 0, 0, 11, OPC_OP_IMM));           // jal target
    put_word(17, enc_u(32'h80000, 12, OPC_LUI));            // lui  x12,0x80000
    put_word(18, enc_i(32'h404, 12, 5, 13, OPC_OP_IMM));    // srai x13,x12,4
    put_word(19, enc_i(4, 12, 5, 14, OPC_OP_IMM));          // srli x14,x12,4
    put_word(20, enc_r(0, 1, 2, 2, 15, OPC_OP));            // slt  x15,x2,x1
    put_word(21, enc_r(0, 1, 2, 3, 16, OPC_OP));            // sltu x16,x2,x1
    put_word(22, enc_u(1, 17, OPC_AUIPC));                  // auipc x17,1
    put_word(23, enc_i(101, 0, 0, 18, OPC_JALR));           // jalr x18,101(x0)
    put_word(24, enc_i(77, 0, 0, 10, OPC_OP_IMM));          // skipped
    put_word(25, enc_i(16, 0, 1, 19, OPC_LOAD));            // lh   x19,16(x0)
    put_word(26, enc_i(16, 0, 5, 20, OPC_LOAD));            // lhu  x20,16(x0)
    put_word(27, enc_i(1, 0, 2, 21, OPC_LOAD));             // lw   x21,1(x0) misaligned
    put_word(28, enc_j(0, 0));                              // halt: jal x0,0
  endtask

  task automatic load_data();
    logic [7:0] pre [0:17];
    pre = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hAB, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h11, 8'hEE, 8'h44, 8'h55, 8'h00, 8'h80};
    for (int i = 0; i < DATA_MEM_SIZE_DEF; i++)
      RISC_V_CPU_inst.Data_Memory.DataMem[i] = 8'(i * 3 + 1);
    for (int i = 0; i < 18; i++)
      RISC_V_CPU_inst.Data_Memory.DataMem[i] = pre[i];
  endtask

  task automatic exp_gpr(input int r, input logic [31:0] v);
    sb.push_back('{1'b0, 8'(r), v});
  endtask
  task automatic exp_mem(input int a, input logic [7:0] v);
    sb.push_back('{1'b1, 8'(a), {24'd0, v}});
  endtask

  task automatic push_expect();
    exp_gpr(0, 32'h0);
    exp_gpr(1, 32'h0);
    exp_gpr(2, 32'hFFFF_FFFD);
    exp_gpr(3, 32'h0000_0002);
    exp_gpr(4, 32'h0000_0008);
    exp_gpr(5, 32'h1234_5678);
    exp_gpr(6, 32'h0000_0012);
    exp_gpr(7, 32'h0000_0078);
`ifdef RISCV_MUL_EN
    exp_gpr(8, 32'hFFFF_FFF1);
`else
    exp_gpr(8, 32'h0);
`endif
    exp_gpr(9, 32'd60);
    exp_gpr(10, 32'h0);
    exp_gpr(11, 32'h1);
    exp_gpr(12, 32'h8000_0000);
    exp_gpr(13, 32'hF800_0000);
    exp_gpr(14, 32'h0800_0000);
    exp_gpr(15, 32'h1);
    exp_gpr(16, 32'h0);
    exp_gpr(17, 32'h0000_1058);
    exp_gpr(18, 32'd96);
    exp_gpr(19, 32'hFFFF_8000);
    exp_gpr(20, 32'h0000_8000);
    exp_gpr(21, 32'hAB12_3456);
    exp_mem(8, 8'h78);
    exp_mem(9, 8'h56);
    exp_mem(10, 8'h34);
    exp_mem(11, 8'h12);
    exp_mem(12, 8'h05);
    exp_mem(13, 8'hEE);
  endtask

  task automatic drain(input string pass_tag);
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_mem) begin
        got = {24'd0, RISC_V_CPU_inst.Data_Memory.DataMem[e.idx]};
        check($sformatf("%s mem[%0d]", pass_tag, e.idx), got, e.val);
      end else begin
        got = RISC_V_CPU_inst.Register_File.GPR[e.idx[4:0]];
        check($sformatf("%s x%0d", pass_tag, e.idx), got, e.val);
      end
    end
  endtask

  task automatic run_to_halt(input string tag);
    int cyc = 0;
    while (RISC_V_CPU_inst.pc !== HALT_PC && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, {31'd0, RISC_V_CPU_inst.pc === HALT_PC}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    logic [31:0] acc = '0;
    for (int i = 0; i < GPR_SIZE_DEF; i++) acc |= RISC_V_CPU_inst.Register_File.GPR[i];
    check({tag, " pc"}, RISC_V_CPU_inst.pc, 32'h0);
    check({tag, " gpr_or"}, acc, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    #1;
    load_program();
    load_data();
    #1;
    check_reset_state("reset0");
    push_expect();
    @(negedge clk);
    rst_n = 1'b1;
    run_to_halt("halt_run1");
    drain("run1");

    // Reset pulse after completion: core clears, RAM keeps what the program wrote.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("reset_pulse");
    check("reset_mem_word", {RISC_V_CPU_inst.Data_Memory.DataMem[3], RISC_V_CPU_inst.Data_Memory.DataMem[2],
                             RISC_V_CPU_inst.Data_Memory.DataMem[1], RISC_V_CPU_inst.Data_Memory.DataMem[0]},
          32'h1234_5678);
    check("reset_mem12", {24'd0, RISC_V_CPU_inst.Data_Memory.DataMem[12]}, 32'h05);
    check("reset_mem13", {24'd0, RISC_V_CPU_inst.Data_Memory.DataMem[13]}, 32'hEE);
    rst_n = 1'b1;

    // Reset asserted between edges mid-program.
    repeat (3) @(negedge clk);
    check("midrun_x1", RISC_V_CPU_inst.Register_File.GPR[1], 32'd5);
    check("midrun_pc", RISC_V_CPU_inst.pc, 32'd12);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("midrun_reset");
    @(negedge clk);
    check("held_reset_pc", RISC_V_CPU_inst.pc, 32'h0);
    rst_n = 1'b1;
    push_expect();
    run_to_halt("halt_run2");
    drain("run2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
